// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: serialises I-cache (client 0) and D-cache (client 1) line requests onto one memory port.
// Optional MEM_ARB_FIXED_PRIO_EN: client 0 always wins ties instead of round-robin.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 64
`endif

module mem_arbiter #(
  parameter int unsigned WIDTH  = `MEMORY_WIDTH,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_write_req,
  input  logic [ADDR_W-1:0] c0_write_addr,
  input  logic [WIDTH-1:0]  c0_write_data,
  output logic              c0_write_ack,
  input  logic              c0_read_req,
  input  logic [ADDR_W-1:0] c0_read_addr,
  output logic [WIDTH-1:0]  c0_read_data,
  output logic              c0_read_ack,
  input  logic              c1_write_req,
  input  logic [ADDR_W-1:0] c1_write_addr,
  input  logic [WIDTH-1:0]  c1_write_data,
  output logic              c1_write_ack,
  input  logic              c1_read_req,
  input  logic [ADDR_W-1:0] c1_read_addr,
  output logic [WIDTH-1:0]  c1_read_data,
  output logic              c1_read_ack,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_t;

  state_t state, state_nxt;
  logic   gnt;
  logic   c0_any_c, c1_any_c, any_req_c, pick_c1_c, sel_wr_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [WIDTH-1:0]  sel_wdata_c;

  assign c0_any_c  = c0_write_req | c0_read_req;
  assign c1_any_c  = c1_write_req | c1_read_req;
  assign any_req_c = c0_any_c | c1_any_c;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick_c1_c = c1_any_c & ~c0_any_c;
`else
  // last_grant = 1 means client 1 was served last, so client 0 wins the next tie
  logic last_grant;

  assign pick_c1_c = c1_any_c & (~c0_any_c | ~last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && any_req_c) begin
      last_grant <= pick_c1_c;
    end
  end
`endif

  // Write-back goes ahead of the fill within the chosen client
  always_comb begin
    sel_wr_c    = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    if (pick_c1_c) begin
      sel_wr_c    = c1_write_req;
      sel_addr_c  = c1_write_req ? c1_write_addr : c1_read_addr;
      sel_wdata_c = c1_write_req ? c1_write_data : '0;
    end else begin
      sel_wr_c    = c0_write_req;
      sel_addr_c  = c0_write_req ? c0_write_addr : c0_read_addr;
      sel_wdata_c = c0_write_req ? c0_write_data : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req_c) state_nxt = ISSUE;
      ISSUE:   if (mem_ack)   state_nxt = RESP;
      RESP:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory operands are held in the output registers from grant until mem_ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt          <= 1'b0;
      mem_req      <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      c0_write_ack <= 1'b0;
      c0_read_ack  <= 1'b0;
      c0_read_data <= '0;
      c1_write_ack <= 1'b0;
      c1_read_ack  <= 1'b0;
      c1_read_data <= '0;
    end else begin
      c0_write_ack <= 1'b0;
      c0_read_ack  <= 1'b0;
      c0_read_data <= '0;
      c1_write_ack <= 1'b0;
      c1_read_ack  <= 1'b0;
      c1_read_data <= '0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            gnt       <= pick_c1_c;
            mem_req   <= 1'b1;
            mem_rw    <= ~sel_wr_c;
            mem_addr  <= sel_addr_c;
            mem_wdata <= sel_wdata_c;
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_rw) begin
              if (gnt) begin
                c1_read_ack  <= 1'b1;
                c1_read_data <= mem_rdata;
              end else begin
                c0_read_ack  <= 1'b1;
                c0_read_data <= mem_rdata;
              end
            end else begin
              c1_write_ack <= gnt;
              c0_write_ack <= ~gnt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model, per-cycle compare, directed scenarios.
`timescale 1ns/1ps

module tb_mem_arbiter;
  localparam int unsigned WIDTH  = 64;
  localparam int unsigned ADDR_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic c0_write_req = 0, c0_read_req = 0, c1_write_req = 0, c1_read_req = 0;
  logic [ADDR_W-1:0] c0_write_addr = '0, c0_read_addr = '0, c1_write_addr = '0, c1_read_addr = '0;
  logic [WIDTH-1:0]  c0_write_data = '0, c1_write_data = '0;
  logic c0_write_ack, c0_read_ack, c1_write_ack, c1_read_ack;
  logic [WIDTH-1:0]  c0_read_data, c1_read_data;
  logic mem_req, mem_rw, mem_ack = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata, mem_rdata = '0;

  int errors = 0;
  int checks = 0;
  int mem_lat = 3;
  logic spur_en = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .c0_write_req(c0_write_req), .c0_write_addr(c0_write_addr), .c0_write_data(c0_write_data),
    .c0_write_ack(c0_write_ack), .c0_read_req(c0_read_req), .c0_read_addr(c0_read_addr),
    .c0_read_data(c0_read_data), .c0_read_ack(c0_read_ack),
    .c1_write_req(c1_write_req), .c1_write_addr(c1_write_addr), .c1_write_data(c1_write_data),
    .c1_write_ack(c1_write_ack), .c1_read_req(c1_read_req), .c1_read_addr(c1_read_addr),
    .c1_read_data(c1_read_data), .c1_read_ack(c1_read_ack),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory responder: acks after mem_lat cycles; read line = {DEADBEEF, addr}
  int cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      mem_ack = 1'b0;
      cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      cnt++;
      if (cnt >= mem_lat) begin
        mem_ack = 1'b1;
        mem_rdata = {32'hDEADBEEF, mem_addr};
        cnt = 0;
      end
    end else begin
      cnt = 0;
      if (spur_en) begin
        mem_ack = 1'b1;
        mem_rdata = '1;
      end
    end
  end

  // Transaction model: grant, hold until mem_ack, ack next cycle, next sample 3 edges after the ack edge
  int   edge_n = 0, m_free = 0;
  logic m_busy = 0, m_last = 1, m_cli = 0, m_wr = 0;
  logic e_req = 0, e_rw = 0, e_wa0 = 0, e_wa1 = 0, e_ra0 = 0, e_ra1 = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [WIDTH-1:0]  e_wdata = '0, e_rd0 = '0, e_rd1 = '0;

  always @(posedge clk or posedge reset) begin
    logic w0, w1;
    if (reset) begin
      edge_n = 0; m_free = 0; m_busy = 0; m_last = 1;
      e_req = 0; e_wa0 = 0; e_wa1 = 0; e_ra0 = 0; e_ra1 = 0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      edge_n++;
      e_wa0 = 0; e_wa1 = 0; e_ra0 = 0; e_ra1 = 0; e_rd0 = '0; e_rd1 = '0;
      w0 = c0_write_req | c0_read_req;
      w1 = c1_write_req | c1_read_req;
      if (m_busy) begin
        if (mem_ack) begin
          m_busy = 0;
          e_req = 0;
          m_free = edge_n + 3;
          if (m_wr) begin
            if (m_cli) e_wa1 = 1; else e_wa0 = 1;
          end else if (m_cli) begin
            e_ra1 = 1; e_rd1 = mem_rdata;
          end else begin
            e_ra0 = 1; e_rd0 = mem_rdata;
          end
        end
      end else if (edge_n >= m_free && (w0 || w1)) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        m_cli = !w0;
`else
        m_cli = (w0 && w1) ? !m_last : w1;
`endif
        m_last = m_cli;
        m_wr   = m_cli ? c1_write_req : c0_write_req;
        e_addr = m_cli ? (m_wr ? c1_write_addr : c1_read_addr) : (m_wr ? c0_write_addr : c0_read_addr);
        e_wdata = m_cli ? c1_write_data : c0_write_data;
        e_rw   = !m_wr;
        e_req  = 1;
        m_busy = 1;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("mem_req", 64'(mem_req), 64'(e_req));
    if (e_req) begin
      chk("mem_rw", 64'(mem_rw), 64'(e_rw));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      if (!e_rw) chk("mem_wdata", mem_wdata, e_wdata);
    end
    chk("c0_write_ack", 64'(c0_write_ack), 64'(e_wa0));
    chk("c1_write_ack", 64'(c1_write_ack), 64'(e_wa1));
    chk("c0_read_ack", 64'(c0_read_ack), 64'(e_ra0));
    chk("c1_read_ack", 64'(c1_read_ack), 64'(e_ra1));
    chk("c0_read_data", c0_read_data, e_rd0);
    chk("c1_read_data", c1_read_data, e_rd1);
  end

  // Grant log: {rw, addr} at each rising mem_req
  logic [32:0] log_q[$];
  logic prev_req = 0;
  always @(negedge clk) begin
    if (mem_req && !prev_req) log_q.push_back({mem_rw, mem_addr});
    prev_req = mem_req;
  end

  function automatic logic [32:0] get_log(input int idx);
    return (log_q.size() > idx) ? log_q[idx] : 33'h1_FFFF_FFFF;
  endfunction

  // Clients drop each req when its ack appears; returns once quiet
  task automatic wait_idle(input int max);
    int quiet = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (c0_write_ack) c0_write_req = 0;
      if (c0_read_ack)  c0_read_req  = 0;
      if (c1_write_ack) c1_write_req = 0;
      if (c1_read_ack)  c1_read_req  = 0;
      if (!(c0_write_req | c0_read_req | c1_write_req | c1_read_req | mem_req)) quiet++;
      else quiet = 0;
      if (quiet >= 4) return;
    end
    chk("wait_idle_timeout", 64'(quiet), 64'd4);
  endtask

  task automatic wait_mem_req(input int max);
    for (int i = 0; i < max && !mem_req; i++) @(negedge clk);
    chk("mem_req_seen", 64'(mem_req), 64'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
  endtask

  initial begin
    int base;
    logic [32:0] exp_first, exp_second;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_c0_read_ack", 64'(c0_read_ack), 64'd0);
    chk("rst_c1_read_data", c1_read_data, 64'd0);
    reset = 0;
    repeat (2) @(negedge clk);

    // Single read from client 1
    mem_lat = 3;
    c1_read_addr = 32'h40; c1_read_req = 1;
    wait_mem_req(10);
    chk("single_rw", 64'(mem_rw), 64'd1);
    chk("single_addr", 64'(mem_addr), 64'h40);
    for (int i = 0; i < 20 && !c1_read_ack; i++) @(negedge clk);
    chk("single_ack", 64'(c1_read_ack), 64'd1);
    chk("single_data", c1_read_data, 64'hDEADBEEF_00000040);
    chk("single_c0_acks", 64'({c0_read_ack, c0_write_ack}), 64'd0);
    c1_read_req = 0;
    wait_idle(50);

    // Evict + fill: write-back first, then read
    base = log_q.size();
    c1_write_addr = 32'h100; c1_write_data = 64'hA5A5_0000_1111_2222;
    c1_read_addr  = 32'h200;
    c1_write_req = 1; c1_read_req = 1;
    wait_idle(100);
    chk("evict_first", 64'(get_log(base)), 64'h0_0000_0100);
    chk("evict_second", 64'(get_log(base + 1)), 64'h1_0000_0200);

    // Req dropped after grant is still served and acked
    c0_write_addr = 32'h600; c0_write_data = 64'h1111_2222_3333_4444;
    c0_write_req = 1;
    wait_mem_req(10);
    c0_write_req = 0;
    for (int i = 0; i < 20 && !c0_write_ack; i++) @(negedge clk);
    chk("dropped_req_ack", 64'(c0_write_ack), 64'd1);
    wait_idle(50);

    // Operand stability while in flight
    mem_lat = 5;
    base = log_q.size();
    c0_read_addr = 32'h10; c0_read_req = 1;
    wait_mem_req(10);
    c0_read_addr = 32'h20;
    @(negedge clk);
    chk("stable_addr_1", 64'(mem_addr), 64'h10);
    @(negedge clk);
    chk("stable_addr_2", 64'(mem_addr), 64'h10);
    wait_idle(50);
    chk("stable_log", 64'(get_log(base)), 64'h1_0000_0010);

    // Spurious mem_ack with nothing in flight
    spur_en = 1;
    repeat (6) @(negedge clk);
    spur_en = 0;
    repeat (2) @(negedge clk);
    chk("spur_mem_req", 64'(mem_req), 64'd0);

    // Contention after reset: client 0 first
    mem_lat = 2;
    pulse_reset();
    base = log_q.size();
    c0_read_addr = 32'h1000; c1_read_addr = 32'h2000;
    c0_read_req = 1; c1_read_req = 1;
    wait_idle(100);
    chk("cont1_first", 64'(get_log(base)), 64'h1_0000_1000);
    chk("cont1_second", 64'(get_log(base + 1)), 64'h1_0000_2000);

    // Solo client 0, then contention again: round-robin favours client 1
    c0_read_addr = 32'h3000; c0_read_req = 1;
    wait_idle(50);
    base = log_q.size();
    c0_read_addr = 32'h1000;
    c0_read_req = 1; c1_read_req = 1;
    wait_idle(100);
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_first = 33'h1_0000_1000; exp_second = 33'h1_0000_2000;
`else
    exp_first = 33'h1_0000_2000; exp_second = 33'h1_0000_1000;
`endif
    chk("cont2_first", 64'(get_log(base)), 64'(exp_first));
    chk("cont2_second", 64'(get_log(base + 1)), 64'(exp_second));

    // Reset mid-transaction: mem_req drops at once, no ack
    mem_lat = 10;
    c1_read_addr = 32'h700; c1_read_req = 1;
    wait_mem_req(10);
    #2 reset = 1;
    #1 chk("midrst_mem_req", 64'(mem_req), 64'd0);
    c1_read_req = 0;
    @(negedge clk);
    chk("midrst_no_ack", 64'(c1_read_ack), 64'd0);
    reset = 0;
    mem_lat = 2;
    c0_read_addr = 32'h800; c0_read_req = 1;
    for (int i = 0; i < 20 && !c0_read_ack; i++) @(negedge clk);
    chk("post_rst_ack", 64'(c0_read_ack), 64'd1);
    chk("post_rst_data", c0_read_data, 64'hDEADBEEF_00000800);
    wait_idle(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-client memory arbiter that sits directly downstream of the instruction and data caches. It consumes the caches' level-sensitive mem_write_req/mem_read_req ports and serialises them onto one main-memory port. Each cache sees the same req/ack protocol it would see from a dedicated memory.

Parameters:
WIDTH, `MEMORY_WIDTH, bits per cache line; width of all data buses.
ADDR_W, 32, address width.

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
c0_write_req  in  1  client 0 (I-cache) line write-back request, level
c0_write_addr  in  ADDR_W  client 0 write address
c0_write_data  in  WIDTH  client 0 write line
c0_write_ack  out  1  client 0 write done, 1-cycle pulse
c0_read_req  in  1  client 0 line fill request, level
c0_read_addr  in  ADDR_W  client 0 read address
c0_read_data  out  WIDTH  client 0 fill data, valid while c0_read_ack=1
c0_read_ack  out  1  client 0 fill done, 1-cycle pulse
c1_*  (same 8 ports)  client 1 (D-cache)
mem_req  out  1  memory transaction request, level
mem_rw  out  1  1=read, 0=write (matches cache read_write convention)
mem_addr  out  ADDR_W  transaction address, line-aligned as supplied
mem_wdata  out  WIDTH  write line
mem_rdata  in  WIDTH  read line, sampled on the posedge where mem_ack=1
mem_ack  in  1  memory completion, sampled on posedge while mem_req=1

Behaviour:
- Reset: all outputs 0, state=IDLE, last_grant=1 (so client 0 wins the first tie).
- States: IDLE, ISSUE, RESP, GAP.
- IDLE: on posedge, if any req is high, pick a client. If both clients request, the client != last_grant wins (round-robin); if one requests, that client wins. Within the chosen client, a write precedes a read when both are high; the cache requires write-back before fill. Latch addr/data/op into holding registers; mem_req<=1, mem_rw, mem_addr, mem_wdata driven from those registers. Update last_grant. Go to ISSUE.
- ISSUE: hold mem_req and operands stable. On the posedge with mem_ack=1: mem_req<=0, capture mem_rdata for reads, go to RESP. mem_ack while not in ISSUE is ignored.
- RESP: the granted client's write_ack or read_ack is high for exactly this one cycle; read_data holds the captured line for this cycle. Go to GAP.
- GAP: one idle cycle so the client can drop its req; no request is sampled. Go to IDLE.
- Minimum latency, request to ack: req seen at edge N; mem_req high N..M; ack pulse from edge M+1 if mem_ack is sampled at M. Back-to-back grants are spaced 3 cycles + memory latency.
- Client req/addr/data changes after the grant edge do not affect the in-flight transaction. A req dropped before its ack is served anyway; the ack is still pulsed.
- Non-granted client ack/data outputs stay 0. Both acks are never high in the same cycle.
- Write and read from one client are two separate transactions. The other client may be granted between them under round-robin.
- Reset mid-transaction: mem_req drops immediately, the ack is not issued, and the transaction is lost. The memory model must tolerate an abandoned request.

Optional Feature:
MEM_ARB_FIXED_PRIO_EN: when defined, client 0 always wins simultaneous requests and last_grant is unused. When undefined, round-robin as above.

Test Plan:
- Single read: c1_read_req=1, addr=0x00000040; mem acks after 3 cycles with 0xDEADBEEF... -> mem_rw=1, mem_addr=0x40; c1_read_ack 1 cycle with c1_read_data equal to the mem_rdata line; c0 acks stay 0.
- Evict+fill: c1_write_req and c1_read_req both high (wr addr 0x100, rd addr 0x200) -> write to 0x100 issued first (mem_rw=0), c1_write_ack pulses; after the next grant, read to 0x200, c1_read_ack pulses.
- Contention: c0_read_req and c1_read_req rise on the same cycle after reset -> c0 granted first, then c1. Repeating the pattern alternates c1, c0 (round-robin). With MEM_ARB_FIXED_PRIO_EN, c0 always wins.
- Operand stability: change c0_read_addr from 0x10 to 0x20 during ISSUE -> mem_addr stays 0x10 until mem_ack.
- Reset mid-ISSUE: assert reset asynchronously between edges -> mem_req=0 immediately, no ack pulse; after release, a new request is served normally.
- Spurious mem_ack in IDLE/GAP -> no state change, no client ack.
